// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - measured input and result bundle for clk_period_meter
interface clk_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             in_clk;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             freq_err;
  logic             stall;

  modport master (
    input  in_clk,
    output period, period_vld, locked, freq_err, stall
  );

  modport slave (
    output in_clk,
    input  period, period_vld, locked, freq_err, stall
  );
endinterface

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures in_clk period in clk cycles, tracks lock, flags errors and stalls
// Optional input deglitch filter enabled by defining CLK_PERIOD_METER_DEGLITCH_EN.
module clk_period_meter #(
  parameter int CNT_W  = 16,
  parameter int EXPECT = 10,
  parameter int TOL    = 1,
  parameter int LOCK_N = 4
) (
  input  logic                clk,
  input  logic                rst,
  clk_period_meter_if.master  bus
);

  localparam logic [CNT_W-1:0] MAX   = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   EXP_V = (CNT_W+1)'(EXPECT);
  localparam logic [CNT_W:0]   TOL_V = (CNT_W+1)'(TOL);
  localparam int               GW    = $clog2(LOCK_N + 1);
  localparam logic [GW-1:0]    GOOD_FULL = GW'(LOCK_N);
  localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    good_q;
  logic [CNT_W-1:0] period_q;
  logic             period_vld_q, locked_q, freq_err_q, stall_q;
  logic             rise;
  logic [CNT_W:0]   cnt_ext, diff;
  logic             in_tol;

`ifdef CLK_PERIOD_METER_DEGLITCH_EN
  // The filtered level only follows s2 once it has held for two samples,
  // so single-cycle pulses and gaps never reach the edge detector.
  logic f_q, f;
  assign f    = (s2_q == s3_q) ? s2_q : f_q;
  assign rise = f & ~f_q;
`else
  logic unused_f;
  assign unused_f = 1'b0;
  assign rise     = s2_q & ~s3_q;
`endif

  assign cnt_d   = (cnt_q == MAX) ? MAX : cnt_q + ONE;
  assign cnt_ext = {1'b0, cnt_q};
  assign diff    = (cnt_ext >= EXP_V) ? (cnt_ext - EXP_V) : (EXP_V - cnt_ext);
  assign in_tol  = (diff <= TOL_V);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      good_q       <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      freq_err_q   <= 1'b0;
      stall_q      <= 1'b0;
`ifdef CLK_PERIOD_METER_DEGLITCH_EN
      f_q          <= 1'b0;
`endif
    end else begin
      s1_q         <= bus.in_clk;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
`ifdef CLK_PERIOD_METER_DEGLITCH_EN
      f_q          <= f;
`endif
      period_vld_q <= 1'b0;
      freq_err_q   <= 1'b0;
      cnt_q        <= cnt_d;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            state_q <= RUN;
            cnt_q   <= ONE;
          end
        end
        RUN: begin
          if (rise) begin
            period_q     <= cnt_q;
            period_vld_q <= 1'b1;
            cnt_q        <= ONE;
            if (in_tol) begin
              if (good_q != GOOD_FULL) good_q <= good_q + GW'(1);
              if (good_q >= GOOD_LAST) locked_q <= 1'b1;
            end else begin
              freq_err_q <= 1'b1;
              good_q     <= '0;
              locked_q   <= 1'b0;
            end
          end else if (cnt_q == MAX) begin
            state_q  <= STALL;
            stall_q  <= 1'b1;
            locked_q <= 1'b0;
            good_q   <= '0;
          end
        end
        STALL: begin
          if (rise) begin
            state_q <= RUN;
            stall_q <= 1'b0;
            cnt_q   <= ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.period_vld = period_vld_q;
  assign bus.locked     = locked_q;
  assign bus.freq_err   = freq_err_q;
  assign bus.stall      = stall_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - scoreboard bench for clk_period_meter against an edge-timing model
module tb_clk_period_meter;
  localparam int CNT_W  = 8;
  localparam int EXPECT = 10;
  localparam int TOL    = 1;
  localparam int LOCK_N = 4;
  localparam int MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int kind;   // 0 = period strobe, 1 = stall entry
    int cyc;
    int period;
    int ferr;
    int locked;
  } exp_t;
  exp_t q[$];
  exp_t e;

  clk_period_meter_if #(.CNT_W(CNT_W)) mif ();

  clk_period_meter #(
    .CNT_W(CNT_W), .EXPECT(EXPECT), .TOL(TOL), .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference model: works on sampled in_clk values and absolute edge times.
  int m_state;  // 0 idle, 1 measuring, 2 stalled
  int m_last, m_good, m_locked;
  bit prev_x, flev;

  function automatic void model_reset();
    m_state = 0; m_last = 0; m_good = 0; m_locked = 0;
    prev_x = 1'b0; flev = 1'b0;
  endfunction

  function automatic void model_edge(int t, bit ev);
    int p;
    bit bad;
    if (m_state != 1) begin
      if (ev) begin
        m_state = 1;
        m_last  = t;
      end
    end else if (ev) begin
      p = t - m_last;
      m_last = t;
      bad = (p > EXPECT + TOL) || (p < EXPECT - TOL);
      if (bad) begin
        m_good = 0; m_locked = 0;
      end else begin
        if (m_good < LOCK_N) m_good++;
        if (m_good == LOCK_N) m_locked = 1;
      end
      q.push_back('{0, t, p, int'(bad), m_locked});
    end else if (t - m_last == MAX) begin
      m_state = 2; m_good = 0; m_locked = 0;
      q.push_back('{1, t, 0, 0, 0});
    end
  endfunction

  // Sample x is taken by the DUT at edge j; its effect is visible after edge j+2.
  function automatic void model_sample(int j, bit x);
    bit ev;
`ifdef CLK_PERIOD_METER_DEGLITCH_EN
    ev = 1'b0;
    if (x == prev_x && x != flev) begin
      flev = x;
      ev   = x;
    end
`else
    ev = x & ~prev_x;
`endif
    prev_x = x;
    model_edge(j + 2, ev);
  endfunction

  task automatic drive(input bit v);
    @(negedge clk);
    mif.in_clk = v;
    model_sample(cyc + 1, v);
  endtask

  task automatic clock_run(input int p, input int n, input int hi);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < p; c++) drive(c < hi);
    end
  endtask

  task automatic glitch_run(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (5) drive(1'b1);
      repeat (2) drive(1'b0);
      drive(1'b1);
      repeat (2) drive(1'b0);
    end
  endtask

  task automatic do_reset_mid();
    chk("locked_before_rst", mif.locked, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    mif.in_clk = 1'b0;
    #1;
    chk("rst_mid_period", mif.period, 0);
    chk("rst_mid_flags", {mif.period_vld, mif.locked, mif.freq_err, mif.stall}, 0);
    q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  bit vld_p = 1'b0;
  bit stall_p = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      vld_p   = 1'b0;
      stall_p = 1'b0;
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (mif.period_vld) begin
        chk("vld_back_to_back", int'(vld_p), 0);
        if (q.size() == 0) begin
          chk("unexpected_vld_queue", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("vld_kind", e.kind, 0);
          chk("vld_cycle", cyc, e.cyc);
          chk("period", mif.period, e.period);
          chk("freq_err", mif.freq_err, e.ferr);
          chk("locked", mif.locked, e.locked);
        end
      end else begin
        chk("freq_err_without_vld", mif.freq_err, 0);
      end
      if (mif.stall && !stall_p) begin
        if (q.size() == 0) begin
          chk("unexpected_stall_queue", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("stall_kind", e.kind, 1);
          chk("stall_cycle", cyc, e.cyc);
          chk("stall_locked", mif.locked, 0);
        end
      end
      vld_p   = mif.period_vld;
      stall_p = mif.stall;
    end
  end

  initial begin
    int p, hi, waited;
    model_reset();
    mif.in_clk = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_period", mif.period, 0);
    chk("reset_flags", {mif.period_vld, mif.locked, mif.freq_err, mif.stall}, 0);
    rst = 1'b1;

    clock_run(10, 8, 5);
    chk("locked_div10", mif.locked, 1);
    clock_run(13, 2, 6);
    clock_run(10, 6, 5);
    glitch_run(3);
    clock_run(10, 6, 5);

    repeat (5) drive(1'b1);
    do_reset_mid();
    clock_run(10, 7, 5);

    clock_run(MAX, 2, 2);
    chk("stall_at_max_gap", mif.stall, 0);
    clock_run(MAX + 1, 2, 2);
    clock_run(10, 6, 5);

    repeat (MAX + 20) drive(1'b0);
    chk("stall_level", mif.stall, 1);
    chk("stall_unlocked", mif.locked, 0);
    clock_run(10, 6, 5);
    chk("stall_cleared", mif.stall, 0);

    for (int i = 0; i < 30; i++) begin
      p  = $urandom_range(2, 20);
      hi = $urandom_range(1, p - 1);
      clock_run(p, 1, hi);
    end
    clock_run(10, 5, 5);

    repeat (10) drive(1'b0);
    waited = 0;
    while (q.size() > 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
